// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with oversampled pins and a byte-wide rd/wr CPU port.
// Define SPI_TARGET_IRQ_EN to add the irq output (rx_valid | CS release held until rd).
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_full,
  output logic       overrun,
  output logic       selected
`ifdef SPI_TARGET_IRQ_EN
  ,
  output logic       irq
`endif
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] sck_q, mosi_q, cs_q;
  logic sck_s, mosi_s, cs_s, sck_d, cs_d;
  logic sck_rise, sck_fall, cs_fall, cs_rise;
  logic active, byte_done, reload;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift, tx_shift;
  logic [7:0] tx_hold, load_byte;
  assign sck_s = sck_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];
  assign cs_s = cs_q[SYNC_STAGES-1];
  assign selected = cs_s;
  always_comb begin
    sck_rise = sck_s & ~sck_d;
    sck_fall = ~sck_s & sck_d;
    cs_fall = cs_s & ~cs_d;
    cs_rise = ~cs_s & cs_d;
    active = state == SHIFT && !cs_rise;
    byte_done = active && sck_rise && bit_cnt == 3'd7;
    reload = (state == IDLE && cs_fall) || (active && sck_fall && bit_cnt == 3'd0);
    load_byte = tx_full ? tx_hold : IDLE_BYTE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q <= '0;
      mosi_q <= '0;
      cs_q <= '0;
      sck_d <= 1'b0;
      cs_d <= 1'b0;
    end else begin
      sck_q <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      cs_q <= {cs_q[SYNC_STAGES-2:0], ~spi_cs_n};
      sck_d <= sck_s;
      cs_d <= cs_s;
    end
  end
  // tx_shift holds only the bits still to go; spi_miso already carries the current one
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bit_cnt <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_hold <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      tx_full <= 1'b0;
      overrun <= 1'b0;
      spi_miso <= 1'b0;
      spi_miso_oe <= 1'b0;
    end else begin
      rx_valid <= byte_done | (rx_valid & ~rd);
      overrun <= ~rd & (overrun | (byte_done & rx_valid));
      tx_full <= wr | (tx_full & ~reload);
      if (wr) tx_hold <= tx_data;
      if (byte_done) rx_data <= {rx_shift, mosi_s};
      if (reload) begin
        tx_shift <= load_byte[6:0];
        spi_miso <= load_byte[7];
      end else if (active && sck_fall) begin
        tx_shift <= {tx_shift[5:0], 1'b0};
        spi_miso <= tx_shift[6];
      end
      if (active && sck_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == IDLE && cs_fall) begin
        state <= SHIFT;
        bit_cnt <= '0;
        spi_miso_oe <= 1'b1;
      end else if (state == SHIFT && cs_rise) begin
        state <= IDLE;
        bit_cnt <= '0;
        spi_miso_oe <= 1'b0;
      end
    end
  end
`ifdef SPI_TARGET_IRQ_EN
  logic cs_flag;
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_flag <= 1'b0;
      irq <= 1'b0;
    end else begin
      cs_flag <= cs_rise | (cs_flag & ~rd);
      irq <= byte_done | (rx_valid & ~rd) | cs_rise | (cs_flag & ~rd);
    end
  end
`endif
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: randomized SPI master against a transaction-level model of the target.
module tb_spi_target;
  localparam int SYNC = 2;
  localparam int H = 4;
  logic clk = 0, reset = 1, spi_sck = 0, spi_mosi = 0, spi_cs_n = 1, rd = 0, wr = 0;
  logic [7:0] tx_data = 0;
  logic spi_miso, spi_miso_oe, rx_valid, tx_full, overrun, selected;
  logic [7:0] rx_data;
`ifdef SPI_TARGET_IRQ_EN
  logic irq;
`endif
  always #5 clk = ~clk;
  spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset(reset), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rd(rd), .wr(wr), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_full(tx_full), .overrun(overrun),
    .selected(selected)
`ifdef SPI_TARGET_IRQ_EN
    , .irq(irq)
`endif
  );
  int errors = 0, checks = 0;
  logic model_ok = 0;
  logic [7:0] m_data = 0, m_hold = 0;
  logic m_valid = 0, m_ovr = 0, m_full = 0, m_irqf = 0;
  logic [31:0] miso_cap = 0;
  task automatic chk1(input string n, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", n, a, e, $time);
    end
  endtask
  task automatic chk8(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [7:0] next_tx();
    if (m_full) begin
      m_full = 0;
      return m_hold;
    end
    return 8'hFF;
  endfunction
  task automatic m_byte(input logic [7:0] b, input logic coinc_rd);
    if (coinc_rd) begin
      m_ovr = 0;
      m_irqf = 0;
    end else if (m_valid) m_ovr = 1;
    m_valid = 1;
    m_data = b;
  endtask
  task automatic do_rd();
    model_ok = 0;
    @(negedge clk) rd = 1;
    @(negedge clk) rd = 0;
    m_valid = 0;
    m_ovr = 0;
    m_irqf = 0;
    model_ok = 1;
  endtask
  task automatic do_wr(input logic [7:0] v);
    model_ok = 0;
    @(negedge clk) begin wr = 1; tx_data = v; end
    @(negedge clk) wr = 0;
    m_hold = v;
    m_full = 1;
    model_ok = 1;
  endtask
  // rd_m/wr_m: per byte, strobe rd at that byte's completion / wr at its trailing boundary reload
  task automatic xfer(input int nbits, input logic [31:0] mo, input logic [3:0] rd_m,
                      input logic [3:0] wr_m, input logic [31:0] wr_v, input logic mid,
                      input logic [7:0] mid_v);
    logic [7:0] txb, rxb;
    logic [31:0] t;
    logic [1:0] bi;
    logic [2:0] k;
    rxb = 0;
    model_ok = 0;
    @(negedge clk) spi_cs_n = 0;
    txb = next_tx();
    repeat (6) @(negedge clk);
    chk1("oe_on", spi_miso_oe, 1'b1);
    chk1("selected_on", selected, 1'b1);
    for (int i = 0; i < nbits; i++) begin
      bi = 2'(i / 8);
      k = 3'(i % 8);
      spi_mosi = mo[5'(31 - i)];
      repeat (H) @(negedge clk);
      chk1("miso", spi_miso, txb[3'd7 - k]);
      miso_cap = {miso_cap[30:0], spi_miso};
      rxb = {rxb[6:0], spi_mosi};
      spi_sck = 1;
      if (k == 3'd7 && rd_m[bi]) begin
        repeat (SYNC) @(negedge clk);
        rd = 1;
        @(negedge clk) rd = 0;
        repeat (H - SYNC - 1) @(negedge clk);
      end else if (mid && i == 3) begin
        @(negedge clk) begin wr = 1; tx_data = mid_v; end
        @(negedge clk) wr = 0;
        m_hold = mid_v;
        m_full = 1;
        repeat (H - 2) @(negedge clk);
      end else repeat (H) @(negedge clk);
      if (k == 3'd7) m_byte(rxb, rd_m[bi]);
      spi_sck = 0;
      if (k == 3'd7) begin
        txb = next_tx();
        if (wr_m[bi]) begin
          t = wr_v << (8 * bi);
          repeat (SYNC) @(negedge clk);
          wr = 1;
          tx_data = t[31:24];
          m_hold = t[31:24];
          m_full = 1;
          @(negedge clk) wr = 0;
        end
      end
    end
    repeat (H) @(negedge clk);
    spi_cs_n = 1;
    repeat (SYNC + 1) @(negedge clk);
    chk1("oe_off", spi_miso_oe, 1'b0);
    chk8("rx_after_cs", rx_data, m_data);
    m_irqf = 1;
    repeat (3) @(negedge clk);
    model_ok = 1;
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (model_ok) begin
      chk8("rx_data", rx_data, m_data);
      chk1("rx_valid", rx_valid, m_valid);
      chk1("overrun", overrun, m_ovr);
      chk1("tx_full", tx_full, m_full);
      chk1("selected", selected, 1'b0);
      chk1("oe_idle", spi_miso_oe, 1'b0);
`ifdef SPI_TARGET_IRQ_EN
      chk1("irq", irq, m_valid | m_irqf);
`endif
    end
  end
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int nb;
    repeat (4) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk8("rst_rx_data", rx_data, 8'h00);
    chk1("rst_rx_valid", rx_valid, 1'b0);
    chk1("rst_tx_full", tx_full, 1'b0);
    chk1("rst_overrun", overrun, 1'b0);
    chk1("rst_miso", spi_miso, 1'b0);
    chk1("rst_oe", spi_miso_oe, 1'b0);
    chk1("rst_selected", selected, 1'b0);
    model_ok = 1;
    repeat (10) begin
      spi_sck = ~spi_sck;
      repeat (H) @(negedge clk);
    end
    chk1("idle_oe", spi_miso_oe, 1'b0);
    chk1("idle_rx_valid", rx_valid, 1'b0);
    do_wr(8'hA5);
    xfer(8, {8'h3C, 24'h0}, 4'b0, 4'b0, 32'h0, 1'b0, 8'h00);
    chk8("miso_a5", miso_cap[7:0], 8'hA5);
    chk8("rx_3c", rx_data, 8'h3C);
    chk1("rx_valid_3c", rx_valid, 1'b1);
    chk1("tx_full_3c", tx_full, 1'b0);
    do_rd();
    xfer(16, {8'h11, 8'h22, 16'h0}, 4'b0, 4'b0, 32'h0, 1'b0, 8'h00);
    chk8("miso_idle0", miso_cap[15:8], 8'hFF);
    chk8("miso_idle1", miso_cap[7:0], 8'hFF);
    chk8("rx_22", rx_data, 8'h22);
    chk1("overrun_set", overrun, 1'b1);
    do_rd();
    chk1("rd_clr_valid", rx_valid, 1'b0);
    chk1("rd_clr_ovr", overrun, 1'b0);
    xfer(5, {5'b10110, 27'h0}, 4'b0, 4'b0, 32'h0, 1'b0, 8'h00);
    chk1("partial_invisible", rx_valid, 1'b0);
    xfer(8, {8'h81, 24'h0}, 4'b0, 4'b0, 32'h0, 1'b0, 8'h00);
    chk8("rx_81", rx_data, 8'h81);
    do_rd();
    do_wr(8'hC3);
    xfer(16, {8'h77, 8'h99, 16'h0}, 4'b0010, 4'b0011, {8'hE7, 8'hF0, 16'h0}, 1'b1, 8'h3D);
    chk8("miso_c3", miso_cap[15:8], 8'hC3);
    chk8("miso_old_hold", miso_cap[7:0], 8'h3D);
    chk8("rx_99", rx_data, 8'h99);
    chk1("coinc_valid", rx_valid, 1'b1);
    chk1("coinc_ovr", overrun, 1'b0);
    chk1("coinc_full", tx_full, 1'b1);
    do_rd();
    xfer(8, 32'h0, 4'b0, 4'b0, 32'h0, 1'b0, 8'h00);
    chk8("miso_new_hold", miso_cap[7:0], 8'hF0);
    do_rd();
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(1) == 1) do_wr(8'($urandom));
      nb = ($urandom_range(3) == 0) ? int'($urandom_range(1, 20)) : 8 * int'($urandom_range(1, 3));
      xfer(nb, $urandom, 4'($urandom), 4'($urandom), $urandom, 1'($urandom), 8'($urandom));
      if ($urandom_range(1) == 1) do_rd();
    end
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
